// File: rtl/iob_soc_opencryptolinux_boot_copier.sv
// Boot copier: copies N_WORDS words from the boot ROM image to SRAM over an IOb
// master port, then writes the boot control register. Per-phase timeout aborts to ERR.
module iob_soc_opencryptolinux_boot_copier #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] SRC_BASE  = '0,
  parameter logic [ADDR_W-1:0] DST_BASE  = '0,
  parameter int                N_WORDS   = 1024,
  parameter logic [ADDR_W-1:0] CTRL_ADDR = '0,
  parameter logic [DATA_W-1:0] CTRL_DATA = DATA_W'(2),
  parameter int                TIMEOUT   = 255
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  arst_n_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic                  iob_avalid_o,
  output logic [ADDR_W-1:0]     iob_addr_o,
  output logic [DATA_W-1:0]     iob_wdata_o,
  output logic [DATA_W/8-1:0]   iob_wstrb_o,
  input  logic                  iob_rvalid_i,
  input  logic [DATA_W-1:0]     iob_rdata_i,
  input  logic                  iob_ready_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (N_WORDS < 1) ? 1 : $clog2(N_WORDS + 1);
  localparam int TO_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(STRB_W);
  localparam logic [CNT_W-1:0]  LAST   = CNT_W'(N_WORDS - 1);
  localparam logic [TO_W-1:0]   TO_LIM = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, CTRL_REQ, DONE, ERR} state_t;

  localparam state_t FIRST = (N_WORDS == 0) ? CTRL_REQ : RD_REQ;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] src_addr, dst_addr;

  // Address arithmetic wraps naturally at ADDR_W bits.
  assign src_addr = SRC_BASE + ADDR_W'(cnt_q) * STEP;
  assign dst_addr = DST_BASE + ADDR_W'(cnt_q) * STEP;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      to_q    <= '0;
      data_q  <= '0;
    end else if (cke_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    to_d         = '0;
    busy_o       = 1'b0;
    iob_avalid_o = 1'b0;
    iob_addr_o   = '0;
    iob_wdata_o  = '0;
    iob_wstrb_o  = '0;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          state_d = FIRST;
          cnt_d   = '0;
        end
      end
      RD_REQ: begin
        busy_o       = 1'b1;
        iob_avalid_o = 1'b1;
        iob_addr_o   = src_addr;
        if (iob_ready_i) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        busy_o     = 1'b1;
        iob_addr_o = src_addr;
        if (iob_rvalid_i) begin
          data_d  = iob_rdata_i;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        busy_o       = 1'b1;
        iob_avalid_o = 1'b1;
        iob_addr_o   = dst_addr;
        iob_wdata_o  = data_q;
        iob_wstrb_o  = '1;
        if (iob_ready_i) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == LAST) ? CTRL_REQ : RD_REQ;
        end
      end
      CTRL_REQ: begin
        busy_o       = 1'b1;
        iob_avalid_o = 1'b1;
        iob_addr_o   = CTRL_ADDR;
        iob_wdata_o  = CTRL_DATA;
        iob_wstrb_o  = '1;
        if (iob_ready_i) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // A phase that makes no progress for TIMEOUT cycles aborts; progress wins on the last cycle.
    if (busy_o && (state_d == state_q)) begin
      if ((TIMEOUT > 0) && (to_q == TO_LIM)) state_d = ERR;
      else                                   to_d    = to_q + 1'b1;
    end
  end

  assign done_o  = (state_q == DONE);
  assign error_o = (state_q == ERR);

endmodule

// File: tb/tb_iob_soc_opencryptolinux_boot_copier.sv
// Bench for the boot copier: random-stall memory slave against a transaction-list
// model, plus directed timeout, zero-length, reset-abort, clock-enable and restart cases.
module tb_iob_soc_opencryptolinux_boot_copier;

  localparam logic [31:0] SRC   = 32'h100;
  localparam logic [31:0] DST   = 32'h8000;
  localparam logic [31:0] CTRLA = 32'h10;

  logic clk = 1'b0;
  logic cke, arst_n;
  always #5 clk = ~clk;

  logic m_start, m_busy, m_done, m_err, m_avalid, m_rvalid, m_ready;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic t_start, t_busy, t_done, t_err, t_avalid, t_rvalid, t_ready;
  logic [31:0] t_addr, t_wdata, t_rdata;
  logic [3:0]  t_wstrb;
  logic z_start, z_busy, z_done, z_err, z_avalid, z_rvalid, z_ready;
  logic [31:0] z_addr, z_wdata, z_rdata;
  logic [3:0]  z_wstrb;

  iob_soc_opencryptolinux_boot_copier #(
    .ADDR_W(32), .DATA_W(32), .SRC_BASE(SRC), .DST_BASE(DST), .N_WORDS(4),
    .CTRL_ADDR(CTRLA), .CTRL_DATA(32'h2), .TIMEOUT(255)
  ) u_main (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .start_i(m_start),
    .busy_o(m_busy), .done_o(m_done), .error_o(m_err),
    .iob_avalid_o(m_avalid), .iob_addr_o(m_addr), .iob_wdata_o(m_wdata), .iob_wstrb_o(m_wstrb),
    .iob_rvalid_i(m_rvalid), .iob_rdata_i(m_rdata), .iob_ready_i(m_ready)
  );

  iob_soc_opencryptolinux_boot_copier #(
    .ADDR_W(32), .DATA_W(32), .SRC_BASE(SRC), .DST_BASE(DST), .N_WORDS(4),
    .CTRL_ADDR(CTRLA), .CTRL_DATA(32'h2), .TIMEOUT(8)
  ) u_tmo (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .start_i(t_start),
    .busy_o(t_busy), .done_o(t_done), .error_o(t_err),
    .iob_avalid_o(t_avalid), .iob_addr_o(t_addr), .iob_wdata_o(t_wdata), .iob_wstrb_o(t_wstrb),
    .iob_rvalid_i(t_rvalid), .iob_rdata_i(t_rdata), .iob_ready_i(t_ready)
  );

  iob_soc_opencryptolinux_boot_copier #(
    .ADDR_W(32), .DATA_W(32), .SRC_BASE(SRC), .DST_BASE(DST), .N_WORDS(0),
    .CTRL_ADDR(CTRLA), .CTRL_DATA(32'h2), .TIMEOUT(255)
  ) u_zero (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .start_i(z_start),
    .busy_o(z_busy), .done_o(z_done), .error_o(z_err),
    .iob_avalid_o(z_avalid), .iob_addr_o(z_addr), .iob_wdata_o(z_wdata), .iob_wstrb_o(z_wstrb),
    .iob_rvalid_i(z_rvalid), .iob_rdata_i(z_rdata), .iob_ready_i(z_ready)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  txn_t        log_q[$];
  logic [31:0] rom [4];
  int          stall_left, rd_left, pend_idx, max_stall;
  bit          pending, was_stalled;
  txn_t        prev;

  // Memory slave for u_main, evaluated once per cycle on the falling edge.
  task automatic slave_step();
    txn_t cur;
    if (pending) begin
      if (rd_left == 0) begin
        m_rvalid = 1'b1;
        m_rdata  = rom[pend_idx];
        pending  = 1'b0;
      end else begin
        m_rvalid = 1'b0;
        rd_left--;
      end
    end else begin
      m_rvalid = ($urandom_range(0, 3) == 0);
      m_rdata  = $urandom;
    end
    if (m_avalid) begin
      cur.addr = m_addr; cur.wdata = m_wdata; cur.wstrb = m_wstrb;
      if (was_stalled) begin
        check("stall_addr", cur.addr, prev.addr);
        check("stall_wdata", cur.wdata, prev.wdata);
        check("stall_wstrb", {28'b0, cur.wstrb}, {28'b0, prev.wstrb});
      end
      if (stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
        was_stalled = 1'b1;
        prev = cur;
      end else begin
        m_ready = 1'b1;
        was_stalled = 1'b0;
        log_q.push_back(cur);
        if (cur.wstrb == 4'h0) begin
          pending  = 1'b1;
          pend_idx = int'(((cur.addr - SRC) >> 2) & 32'h3);
          rd_left  = $urandom_range(0, max_stall);
        end
        stall_left = $urandom_range(0, max_stall);
      end
    end else begin
      m_ready = 1'($urandom_range(0, 1));
      was_stalled = 1'b0;
    end
  endtask

  // Expected bus contents: read word k, write it to DST, then the control write.
  task automatic check_log(input string tag);
    txn_t exp_q[$];
    txn_t e;
    for (int k = 0; k < 4; k++) begin
      e.addr = SRC + 32'(4 * k); e.wdata = '0; e.wstrb = 4'h0; exp_q.push_back(e);
      e.addr = DST + 32'(4 * k); e.wdata = rom[k]; e.wstrb = 4'hF; exp_q.push_back(e);
    end
    e.addr = CTRLA; e.wdata = 32'h2; e.wstrb = 4'hF; exp_q.push_back(e);
    check({tag, "_len"}, log_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < log_q.size(); j++) begin
      check($sformatf("%s_addr%0d", tag, j), log_q[j].addr, exp_q[j].addr);
      check($sformatf("%s_wstrb%0d", tag, j), {28'b0, log_q[j].wstrb}, {28'b0, exp_q[j].wstrb});
      if (exp_q[j].wstrb != 4'h0)
        check($sformatf("%s_wdata%0d", tag, j), log_q[j].wdata, exp_q[j].wdata);
    end
  endtask

  task automatic slave_init(input int max_s);
    log_q.delete();
    pending = 1'b0; was_stalled = 1'b0; max_stall = max_s;
    stall_left = $urandom_range(0, max_s);
    m_rvalid = 1'b0; m_ready = 1'b0;
    for (int k = 0; k < 4; k++) rom[k] = $urandom;
  endtask

  task automatic run_copy(input int max_s, input bit hold, input string tag);
    bit fin, saw_err;
    slave_init(max_s);
    @(negedge clk); m_start = 1'b1;
    fin = 1'b0; saw_err = 1'b0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(negedge clk);
      if (!hold) m_start = 1'b0;
      if (m_err) saw_err = 1'b1;
      if (m_done || m_err) fin = 1'b1;
      else slave_step();
    end
    check({tag, "_finished"}, {31'b0, fin}, 32'd1);
    check({tag, "_error"}, {31'b0, saw_err}, 32'd0);
    check({tag, "_done"}, {31'b0, m_done}, 32'd1);
    check({tag, "_busy"}, {31'b0, m_busy}, 32'd0);
    check({tag, "_avalid"}, {31'b0, m_avalid}, 32'd0);
    check_log(tag);
  endtask

  initial begin
    bit found, hit_ctrl;
    int wr_cyc, nz;
    txn_t zt;

    cke = 1'b1; arst_n = 1'b0;
    m_start = 0; m_rvalid = 0; m_ready = 0; m_rdata = '0;
    t_start = 0; t_rvalid = 0; t_ready = 0; t_rdata = '0;
    z_start = 0; z_rvalid = 0; z_ready = 0; z_rdata = '0;
    #2;
    check("rst_busy", {31'b0, m_busy}, 32'd0);
    check("rst_done", {31'b0, m_done}, 32'd0);
    check("rst_err", {31'b0, m_err}, 32'd0);
    check("rst_avalid", {31'b0, m_avalid}, 32'd0);
    check("rst_addr", m_addr, 32'd0);
    check("rst_wdata", m_wdata, 32'd0);
    check("rst_wstrb", {28'b0, m_wstrb}, 32'd0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;

    run_copy(0, 1'b0, "zero_wait");

    // Clock enable low: start is not seen and DONE holds.
    @(negedge clk); cke = 1'b0; m_start = 1'b1;
    repeat (3) @(negedge clk);
    check("cke_done", {31'b0, m_done}, 32'd1);
    check("cke_busy", {31'b0, m_busy}, 32'd0);
    m_start = 1'b0; @(negedge clk); cke = 1'b1;

    run_copy(10, 1'b0, "rand_stall_a");
    run_copy(10, 1'b0, "rand_stall_b");

    // start held high: one copy, then DONE restarts it.
    run_copy(3, 1'b1, "hold_start");
    @(posedge clk); #1;
    check("restart_busy", {31'b0, m_busy}, 32'd1);
    check("restart_done", {31'b0, m_done}, 32'd0);
    check("restart_addr", m_addr, SRC);
    m_start = 1'b0;
    run_copy(2, 1'b0, "restart_copy");

    // Reset while word 2 is being read.
    slave_init(0);
    @(negedge clk); m_start = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      m_start = 1'b0;
      if (m_avalid && m_wstrb == 4'h0 && m_addr == SRC + 32'h8) found = 1'b1;
      else slave_step();
    end
    check("rst_mid_reached", {31'b0, found}, 32'd1);
    #2 arst_n = 1'b0;
    #1;
    check("rst_mid_avalid", {31'b0, m_avalid}, 32'd0);
    check("rst_mid_addr", m_addr, 32'd0);
    check("rst_mid_wstrb", {28'b0, m_wstrb}, 32'd0);
    check("rst_mid_busy", {31'b0, m_busy}, 32'd0);
    @(negedge clk); arst_n = 1'b1;
    m_ready = 1'b1; m_rvalid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("post_rst_idle%0d", c), {31'b0, m_avalid | m_busy}, 32'd0);
    end
    run_copy(4, 1'b0, "after_rst");

    // Timeout: writes are never accepted.
    t_rvalid = 1'b1; t_rdata = 32'hCAFE_0001; t_ready = 1'b0;
    @(negedge clk); t_start = 1'b1;
    wr_cyc = 0; hit_ctrl = 1'b0;
    for (int c = 0; c < 200 && !t_err; c++) begin
      @(negedge clk);
      t_start = 1'b0;
      if (!t_err) begin
        if (t_avalid && t_wstrb != 4'h0) wr_cyc++;
        if (t_avalid && t_addr == CTRLA) hit_ctrl = 1'b1;
        t_ready = (t_wstrb == 4'h0);
      end
    end
    check("tmo_err", {31'b0, t_err}, 32'd1);
    check("tmo_wr_cycles", wr_cyc, 32'd8);
    check("tmo_avalid", {31'b0, t_avalid}, 32'd0);
    check("tmo_busy", {31'b0, t_busy}, 32'd0);
    check("tmo_done", {31'b0, t_done}, 32'd0);
    check("tmo_no_ctrl", {31'b0, hit_ctrl}, 32'd0);
    t_start = 1'b1; t_ready = 1'b0;
    @(negedge clk); t_start = 1'b0;
    check("tmo_restart_err", {31'b0, t_err}, 32'd0);
    check("tmo_restart_avalid", {31'b0, t_avalid}, 32'd1);
    check("tmo_restart_addr", t_addr, SRC);
    check("tmo_restart_wstrb", {28'b0, t_wstrb}, 32'd0);

    // Zero-length copy: only the control write.
    z_ready = 1'b1; nz = 0; zt.addr = '0; zt.wdata = '0; zt.wstrb = '0;
    @(negedge clk); z_start = 1'b1;
    for (int c = 0; c < 50 && !z_done; c++) begin
      @(negedge clk);
      z_start = 1'b0;
      if (z_avalid) begin
        nz++;
        zt.addr = z_addr; zt.wdata = z_wdata; zt.wstrb = z_wstrb;
      end
    end
    check("zero_count", nz, 32'd1);
    check("zero_addr", zt.addr, CTRLA);
    check("zero_wdata", zt.wdata, 32'h2);
    check("zero_wstrb", {28'b0, zt.wstrb}, 32'hF);
    check("zero_done", {31'b0, z_done}, 32'd1);
    check("zero_busy", {31'b0, z_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
